// File: rtl/mmio_responder_if.sv
// mmio_responder_if: MEM-stage bus between the pipeline and the MMIO responder.
interface mmio_responder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Hit;

    modport master (
        output MemRead, MemWrite, Address, WriteData,
        input  ReadData, Hit
    );

    modport slave (
        input  MemRead, MemWrite, Address, WriteData,
        output ReadData, Hit
    );
endinterface

// File: rtl/mmio_responder.sv
// mmio_responder: 32-byte MMIO window with output port, synchronized input port,
// rising-edge capture and a one-shot/auto-reload down-counting timer.
module mmio_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h1001_0100
) (
    input  logic            clk,
    input  logic            reset,
    mmio_responder_if.slave bus,
    input  logic [7:0]      PortIn,
    output logic [31:0]     PortOut,
    output logic            TimerIrq
);
    logic [7:0]  syncA, syncB, edgeFlags;
    logic [1:0]  timerCtrl;
    logic [31:0] timerLoad, timerCount;
    logic [2:0]  offset;
    logic        expired, wrEn, expire;

    assign bus.Hit  = bus.Address[31:5] == BASE_ADDR[31:5] && bus.Address[1:0] == 2'b00;
    assign offset   = bus.Address[4:2];
    assign wrEn     = bus.MemWrite && bus.Hit;
    assign expire   = timerCtrl[0] && timerCount == 32'd0;
    assign TimerIrq = expired;

    always_comb begin
        bus.ReadData = 32'd0;
        if (bus.MemRead && bus.Hit && !reset)
            case (offset)
                3'd0:    bus.ReadData = PortOut;
                3'd1:    bus.ReadData = {24'd0, syncB};
                3'd2:    bus.ReadData = {24'd0, edgeFlags};
                3'd3:    bus.ReadData = {30'd0, timerCtrl};
                3'd4:    bus.ReadData = timerLoad;
                3'd5:    bus.ReadData = timerCount;
                3'd6:    bus.ReadData = {31'd0, expired};
                default: bus.ReadData = 32'd0;
            endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            PortOut    <= '0;
            syncA      <= '0;
            syncB      <= '0;
            edgeFlags  <= '0;
            timerCtrl  <= '0;
            timerLoad  <= '0;
            timerCount <= '0;
            expired    <= 1'b0;
        end else begin
            syncA <= PortIn;
            syncB <= syncA;
            // syncA & ~syncB is the rise that syncB is about to show; set beats W1C
            edgeFlags <= (edgeFlags & ~((wrEn && offset == 3'd2) ? bus.WriteData[7:0] : 8'h00))
                         | (syncA & ~syncB);
            if (wrEn && offset == 3'd0)
                PortOut <= bus.WriteData;
            if (wrEn && offset == 3'd3)
                timerCtrl <= bus.WriteData[1:0];
            else if (expire && !timerCtrl[1])
                timerCtrl[0] <= 1'b0;
            if (wrEn && offset == 3'd4) begin
                timerLoad  <= bus.WriteData;
                timerCount <= bus.WriteData;
            end else if (expire)
                timerCount <= timerCtrl[1] ? timerLoad : 32'd0;
            else if (timerCtrl[0])
                timerCount <= timerCount - 32'd1;
            expired <= expire || (expired && !(wrEn && offset == 3'd6 && bus.WriteData[0]));
        end
    end
endmodule
